// File: rtl/seg7_mux_scanner.sv
// Six-digit multiplexed seven-segment scanner with a double-buffered pattern
// store and a blanking gap at the start of every digit slot.
module seg7_mux_scanner #(
    parameter int DVSR  = 50000,
    parameter int BLANK = 1000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] seg5,
    input  logic [7:0] seg4,
    input  logic [7:0] seg3,
    input  logic [7:0] seg2,
    input  logic [7:0] seg1,
    input  logic [7:0] seg0,
    output logic [5:0] an,
    output logic [7:0] sseg,
    output logic       frame_done
);

    localparam int            CW        = $clog2(DVSR);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DVSR - 1);
    localparam logic [2:0]    IDX_FIRST = 3'd5;

    logic [CW-1:0]   cnt, cnt_next;
    logic [2:0]      idx, idx_next;
    logic [5:0][7:0] seg_in;
    logic [5:0][7:0] shadow, shadow_next;
    logic [5:0][7:0] active, active_next;
    logic            pending, pending_next;
    logic            slot_end, frame_end, in_blank;
    logic [5:0]      an_next;
    logic [7:0]      sseg_next;
    logic            frame_done_next;

    assign seg_in    = {seg5, seg4, seg3, seg2, seg1, seg0};
    assign slot_end  = en && (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == 3'd0);

    generate
        if (BLANK == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (cnt < CW'(BLANK));
        end
    endgenerate

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        cnt_next        = cnt;
        idx_next        = idx;
        shadow_next     = shadow;
        active_next     = active;
        pending_next    = pending;
        an_next         = 6'b111111;
        sseg_next       = 8'hFF;
        frame_done_next = frame_end;

        if (load) begin
            shadow_next  = seg_in;
            pending_next = 1'b1;
        end

        if (en) begin
            if (slot_end) begin
                cnt_next = '0;
                idx_next = (idx == 3'd0 || idx > IDX_FIRST) ? IDX_FIRST : idx - 3'd1;
            end else begin
                cnt_next = cnt + CW'(1);
            end
        end

        // A load landing on the boundary bypasses the shadow so it costs no extra frame.
        if (frame_end) begin
            if (load) begin
                active_next = seg_in;
            end else if (pending) begin
                active_next = shadow;
            end
            pending_next = 1'b0;
        end

        if (en && !in_blank) begin
            case (idx)
                3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5: begin
                    an_next   = ~(6'b000001 << idx);
                    sseg_next = active[idx];
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            // NOTE: the pattern buffers are reset on purpose so the display shows blank, not garbage.
            cnt        <= '0;
            idx        <= IDX_FIRST;
            shadow     <= '1;
            active     <= '1;
            pending    <= 1'b0;
            an         <= 6'b111111;
            sseg       <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            idx        <= idx_next;
            shadow     <= shadow_next;
            active     <= active_next;
            pending    <= pending_next;
            an         <= an_next;
            sseg       <= sseg_next;
            frame_done <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_seg7_mux_scanner.sv
// Directed bench for seg7_mux_scanner (DVSR=10, BLANK=2, plus a BLANK=0 copy);
// each scenario task computes its expected display cycle by cycle.
module tb_seg7_mux_scanner;

    localparam int DVSR  = 10;
    localparam int BLANK = 2;
    localparam int FRAME = 6 * DVSR;

    typedef logic [5:0][7:0] pat_t;

    localparam pat_t P_OFF    = {6{8'hFF}};
    localparam pat_t P_DIGITS = {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92};
    localparam pat_t P_80     = {6{8'h80}};
    localparam pat_t P_90     = {6{8'h90}};
    localparam pat_t P_HEX    = {8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    localparam pat_t P_ALT    = {8'hF8, 8'h80, 8'h90, 8'hC0, 8'hF9, 8'hA4};

    logic       clk = 1'b0;
    logic       clr, en, load;
    logic [7:0] seg5, seg4, seg3, seg2, seg1, seg0;
    logic [5:0] an, an_b;
    logic [7:0] sseg, sseg_b;
    logic       frame_done, frame_done_b;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    seg7_mux_scanner #(.DVSR(DVSR), .BLANK(BLANK)) dut (
        .clk(clk), .clr(clr), .en(en), .load(load),
        .seg5(seg5), .seg4(seg4), .seg3(seg3), .seg2(seg2), .seg1(seg1), .seg0(seg0),
        .an(an), .sseg(sseg), .frame_done(frame_done)
    );

    seg7_mux_scanner #(.DVSR(DVSR), .BLANK(0)) dut_b (
        .clk(clk), .clr(clr), .en(en), .load(load),
        .seg5(seg5), .seg4(seg4), .seg3(seg3), .seg2(seg2), .seg1(seg1), .seg0(seg0),
        .an(an_b), .sseg(sseg_b), .frame_done(frame_done_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_segs(input pat_t p);
        seg5 = p[5];
        seg4 = p[4];
        seg3 = p[3];
        seg2 = p[2];
        seg1 = p[1];
        seg0 = p[0];
    endtask

    // Walks n_cycles of a frame that starts at idx=5, cnt=0; output after step o
    // reflects scan position o. Optional one-cycle load and optional enable freeze.
    task automatic expect_frame(input string name, input pat_t exp_pat, input int n_cycles,
                                input int load_at, input pat_t load_pat,
                                input int freeze_at, input int freeze_len, input pat_t freeze_pat);
        int         d;
        int         c;
        logic [5:0] exp_an;
        logic [7:0] exp_sseg;
        logic       exp_fd;
        for (int o = 0; o < n_cycles; o++) begin
            if (o == freeze_at) begin
                en = 1'b0;
                drive_segs(freeze_pat);
                load = 1'b1;
                for (int f = 0; f < freeze_len; f++) begin
                    step();
                    load = 1'b0;
                    tests_run++;
                    if (an !== 6'b111111 || sseg !== 8'hFF || frame_done !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL %s freeze f=%0d: got an=%b sseg=%h fd=%b, want an=111111 sseg=ff fd=0",
                                 name, f, an, sseg, frame_done);
                    end
                end
                en = 1'b1;
            end
            if (o == load_at) begin
                drive_segs(load_pat);
                load = 1'b1;
            end
            step();
            load = 1'b0;
            d        = 5 - o / DVSR;
            c        = o % DVSR;
            exp_an   = (c < BLANK) ? 6'b111111 : ~(6'b000001 << d);
            exp_sseg = (c < BLANK) ? 8'hFF : exp_pat[d];
            exp_fd   = (o == FRAME - 1);
            tests_run++;
            if (an !== exp_an) begin
                tests_failed++;
                $display("FAIL %s an o=%0d: got %b want %b", name, o, an, exp_an);
            end
            tests_run++;
            if (sseg !== exp_sseg) begin
                tests_failed++;
                $display("FAIL %s sseg o=%0d: got %h want %h", name, o, sseg, exp_sseg);
            end
            tests_run++;
            if (frame_done !== exp_fd) begin
                tests_failed++;
                $display("FAIL %s frame_done o=%0d: got %b want %b", name, o, frame_done, exp_fd);
            end
        end
    endtask

    task automatic test_reset();
        clr  = 1'b1;
        en   = 1'b1;
        load = 1'b0;
        drive_segs(P_OFF);
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (an !== 6'b111111 || sseg !== 8'hFF || frame_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset cycle %0d: got an=%b sseg=%h fd=%b, want an=111111 sseg=ff fd=0",
                         i, an, sseg, frame_done);
            end
        end
        clr = 1'b0;
    endtask

    task automatic test_first_frame();
        expect_frame("first_frame", P_OFF, FRAME, 0, P_DIGITS, -1, 0, P_OFF);
        expect_frame("second_frame", P_DIGITS, FRAME, -1, P_OFF, -1, 0, P_OFF);
    endtask

    task automatic test_tear_free();
        expect_frame("tear_free_old", P_DIGITS, FRAME, 35, P_80, -1, 0, P_OFF);
    endtask

    task automatic test_coincident_load();
        expect_frame("coincident_pre", P_80, FRAME, FRAME - 1, P_90, -1, 0, P_OFF);
    endtask

    task automatic test_enable_freeze();
        expect_frame("freeze", P_90, FRAME, -1, P_OFF, 24, 25, P_HEX);
    endtask

    task automatic test_mid_reset();
        expect_frame("pre_reset", P_HEX, 14, -1, P_OFF, -1, 0, P_OFF);
        clr = 1'b1;
        step();
        clr = 1'b0;
        tests_run++;
        if (an !== 6'b111111 || sseg !== 8'hFF || frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: got an=%b sseg=%h fd=%b, want an=111111 sseg=ff fd=0",
                     an, sseg, frame_done);
        end
        expect_frame("post_reset", P_OFF, FRAME, 40, P_DIGITS, -1, 0, P_OFF);
        expect_frame("post_reset_reload", P_DIGITS, FRAME, -1, P_OFF, -1, 0, P_OFF);
    endtask

    task automatic test_blank_zero();
        int         d;
        logic [5:0] exp_an;
        logic [7:0] exp_sseg;
        clr = 1'b1;
        step();
        clr = 1'b0;
        tests_run++;
        if (an_b !== 6'b111111 || sseg_b !== 8'hFF || frame_done_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL blank0 reset: got an=%b sseg=%h fd=%b", an_b, sseg_b, frame_done_b);
        end
        for (int o = 0; o < 2 * FRAME; o++) begin
            if (o == 0) begin
                drive_segs(P_ALT);
                load = 1'b1;
            end
            step();
            load     = 1'b0;
            d        = 5 - (o % FRAME) / DVSR;
            exp_an   = ~(6'b000001 << d);
            exp_sseg = (o < FRAME) ? 8'hFF : P_ALT[d];
            tests_run++;
            if ($countones(~an_b) != 1 || an_b !== exp_an) begin
                tests_failed++;
                $display("FAIL blank0 an o=%0d: got %b want %b", o, an_b, exp_an);
            end
            tests_run++;
            if (sseg_b !== exp_sseg) begin
                tests_failed++;
                $display("FAIL blank0 sseg o=%0d: got %h want %h", o, sseg_b, exp_sseg);
            end
            tests_run++;
            if (frame_done_b !== (o % FRAME == FRAME - 1)) begin
                tests_failed++;
                $display("FAIL blank0 frame_done o=%0d: got %b", o, frame_done_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_tear_free();
        expect_frame("tear_free_new", P_80, FRAME, -1, P_OFF, -1, 0, P_OFF);
        test_coincident_load();
        test_enable_freeze();
        test_mid_reset();
        test_blank_zero();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
